// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding used by the add/subtract datapath.
package alu_pkg;

    typedef logic op_t;

    localparam op_t OP_ADD = 1'b0;
    localparam op_t OP_SUB = 1'b1;

endpackage

// File: rtl/add_chunk.sv
// Combinational C-bit adder slice with carry in/out; one slice per pipeline stage.
module add_chunk #(
    parameter int C = 8
) (
    input  logic [C-1:0] a,
    input  logic [C-1:0] b,
    input  logic         cin,
    output logic [C-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{C{1'b0}}, cin};

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined add/subtract unit: a W-bit operation is split into STAGES carry-linked chunks,
// one chunk per stage, with valid/ready flow control on both sides.
module add_sub_pipe
    import alu_pkg::*;
#(
    parameter int W      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    input  logic         i_carry,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [W-1:0] o_result,
    output logic         o_carry,
    output logic         overflow,
    output logic         zero,
    output logic         negative
);

    localparam int C = W / STAGES;

    if (STAGES < 1 || W % STAGES != 0) begin : g_bad_cfg
        $error("add_sub_pipe: W (%0d) must be a positive multiple of STAGES (%0d)", W, STAGES);
    end

    // Per-stage state. Operand registers hold the not-yet-added high bits shifted down,
    // so the next chunk is always at [C-1:0]; res_q holds the low bits finished so far.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] a_sign_q;
    logic [STAGES-1:0] b_sign_q;
    op_t  [STAGES-1:0] op_q;
    logic [W-1:0]      a_q   [STAGES];
    logic [W-1:0]      b_q   [STAGES];
    logic [W-1:0]      res_q [STAGES];

    logic [W-1:0] b_eff;
    logic         cin_eff;

    assign b_eff    = (op == OP_SUB) ? ~b : b;
    assign cin_eff  = (op == OP_SUB) ? ~i_carry : i_carry;
    assign in_ready = !rst && adv[0];
    assign o_valid  = v_q[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [W-1:0] a_in, b_in, res_in, res_full;
        logic         v_in, c_in, a_sign_in, b_sign_in;
        op_t          op_in;
        logic [C-1:0] sum;
        logic         cout;

        if (k == 0) begin : g_src
            assign v_in      = in_valid;
            assign a_in      = a;
            assign b_in      = b_eff;
            assign res_in    = '0;
            assign c_in      = cin_eff;
            assign op_in     = op;
            assign a_sign_in = a[W-1];
            assign b_sign_in = b_eff[W-1];
        end else begin : g_src
            assign v_in      = v_q[k-1];
            assign a_in      = a_q[k-1];
            assign b_in      = b_q[k-1];
            assign res_in    = res_q[k-1];
            assign c_in      = c_q[k-1];
            assign op_in     = op_q[k-1];
            assign a_sign_in = a_sign_q[k-1];
            assign b_sign_in = b_sign_q[k-1];
        end

        // A stage moves unless it and every stage after it are full and the output is blocked.
        assign adv[k] = o_ready || !(&v_q[STAGES-1:k]);

        add_chunk #(.C(C)) u_chunk (
            .a    (a_in[C-1:0]),
            .b    (b_in[C-1:0]),
            .cin  (c_in),
            .sum  (sum),
            .cout (cout)
        );

        assign res_full = res_in | (W'(sum) << (k * C));

        // NOTE: sequential state uses non-blocking assignments so every stage samples
        // its predecessor's pre-edge value; blocking here would collapse the pipeline.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q[k] <= 1'b0;
            end else if (adv[k]) begin
                v_q[k] <= v_in;
            end
        end

        // NOTE: datapath registers carry no reset; their contents are qualified by v_q,
        // so resetting them would only add fan-out on rst.
        always_ff @(posedge clk) begin
            if (adv[k]) begin
                a_q[k]      <= a_in >> C;
                b_q[k]      <= b_in >> C;
                res_q[k]    <= res_full;
                c_q[k]      <= cout;
                op_q[k]     <= op_in;
                a_sign_q[k] <= a_sign_in;
                b_sign_q[k] <= b_sign_in;
            end
        end

        if (k == STAGES - 1) begin : g_out
            always_ff @(posedge clk) begin
                if (rst) begin
                    o_result <= '0;
                    o_carry  <= 1'b0;
                    overflow <= 1'b0;
                    zero     <= 1'b0;
                    negative <= 1'b0;
                end else if (adv[k]) begin
                    o_result <= res_full;
                    o_carry  <= cout ^ (op_in == OP_SUB);
                    overflow <= (a_sign_in == b_sign_in) && (res_full[W-1] != a_sign_in);
                    zero     <= (res_full == '0);
                    negative <= res_full[W-1];
                end
            end
        end
    end

    // The final stage's working registers have no later consumer; results leave via g_out.
    logic unused_tail;
    assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1], res_q[STAGES-1], c_q[STAGES-1],
                           op_q[STAGES-1], a_sign_q[STAGES-1], b_sign_q[STAGES-1]};

endmodule

// File: tb/tb_add_sub_pipe.sv
// Scoreboard bench for add_sub_pipe: three configurations (32/4, 32/1, 64/8) driven in lockstep,
// expectations queued at accept time and checked by a separate output monitor.
module tb_add_sub_pipe;
    import alu_pkg::*;

    typedef struct packed {
        logic [63:0] res;
        logic        c;
        logic        ov;
        logic        z;
        logic        n;
    } resp_t;

    typedef struct {
        resp_t r;
        int    t;
        bit    lat;
    } exp_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        op;
        logic        ci;
        resp_t       e32;
        resp_t       e64;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        drv_valid = 1'b0;
    logic        solo      = 1'b0;
    logic        o_ready   = 1'b1;
    logic [63:0] drv_a     = '0;
    logic [63:0] drv_b     = '0;
    logic        drv_op    = 1'b0;
    logic        drv_ci    = 1'b0;

    logic        rdy4, rdy1, rdy8, rdy_all, iv4, iv1, iv8;
    logic        ov4, ov1, ov8;
    logic [31:0] res4, res1;
    logic [63:0] res8;
    logic        c4, of4, z4, n4, c1, of1, z1, n1, c8, of8, z8, n8;

    // Only offer a beat when every instance can take it, so all three stay in step.
    assign rdy_all = rdy4 && rdy1 && rdy8;
    assign iv4     = drv_valid && (solo || rdy_all);
    assign iv1     = drv_valid && !solo && rdy_all;
    assign iv8     = drv_valid && !solo && rdy_all;

    add_sub_pipe #(.W(32), .STAGES(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4), .a(drv_a[31:0]), .b(drv_b[31:0]),
        .op(drv_op), .i_carry(drv_ci), .o_valid(ov4), .o_ready(o_ready), .o_result(res4),
        .o_carry(c4), .overflow(of4), .zero(z4), .negative(n4)
    );

    add_sub_pipe #(.W(32), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .a(drv_a[31:0]), .b(drv_b[31:0]),
        .op(drv_op), .i_carry(drv_ci), .o_valid(ov1), .o_ready(o_ready), .o_result(res1),
        .o_carry(c1), .overflow(of1), .zero(z1), .negative(n1)
    );

    add_sub_pipe #(.W(64), .STAGES(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .a(drv_a), .b(drv_b),
        .op(drv_op), .i_carry(drv_ci), .o_valid(ov8), .o_ready(o_ready), .o_result(res8),
        .o_carry(c8), .overflow(of8), .zero(z8), .negative(n8)
    );

    exp_t q4[$];
    exp_t q1[$];
    exp_t q8[$];
    exp_t e4, e1, e8;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_out(input string name, input int s, input exp_t e, input resp_t act);
        check({name, " result/flags"}, act, e.r);
        if (e.lat) check({name, " latency"}, 68'(cyc - e.t), 68'(s));
    endtask

    function automatic resp_t rsp(input logic [63:0] r, input logic [3:0] f);
        return {r, f};
    endfunction

    // Whole-word reference: sum/difference at width w with carry/borrow and flags.
    function automatic resp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                    input logic sub, input logic ci);
        logic [63:0] mask, aa, be, r;
        logic [64:0] s;
        resp_t       e;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        aa   = a & mask;
        be   = (sub ? ~b : b) & mask;
        s    = {1'b0, aa} + {1'b0, be} + 65'(sub ^ ci);
        r    = s[63:0] & mask;
        e.res = r;
        e.c   = sub ^ s[w];
        e.ov  = (aa[w-1] == be[w-1]) && (r[w-1] != aa[w-1]);
        e.z   = (r == 64'd0);
        e.n   = r[w-1];
        return e;
    endfunction

    function automatic vec_t mk(input logic [63:0] a, input logic [63:0] b, input logic sub,
                                input logic ci);
        vec_t v;
        v.a   = a;
        v.b   = b;
        v.op  = sub;
        v.ci  = ci;
        v.e32 = model(32, a, b, sub, ci);
        v.e64 = model(64, a, b, sub, ci);
        return v;
    endfunction

    // Drive one beat and wait (bounded) until it is accepted; expectations queue at acceptance.
    task automatic issue(input vec_t v, input bit lat);
        bit got;
        got       = 1'b0;
        drv_a     = v.a;
        drv_b     = v.b;
        drv_op    = v.op;
        drv_ci    = v.ci;
        drv_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (solo ? rdy4 : rdy_all) begin
                got = 1'b1;
                q4.push_back('{r: v.e32, t: cyc, lat: lat});
                if (!solo) begin
                    q1.push_back('{r: v.e32, t: cyc, lat: lat});
                    q8.push_back('{r: v.e64, t: cyc, lat: lat});
                end
            end
        end
        if (!got) check("in_ready wait timeout", 68'(solo ? rdy4 : rdy_all), 68'd1);
        @(posedge clk);
        #1 drv_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q4.size() + q1.size() + q8.size()) != 0; i++) @(negedge clk);
        check("drain S4 leftover", 68'(q4.size()), 68'd0);
        check("drain S1 leftover", 68'(q1.size()), 68'd0);
        check("drain S8 leftover", 68'(q8.size()), 68'd0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: independent of stimulus, consumes one expectation per accepted result.
    always @(negedge clk) begin
        if (!rst && o_ready) begin
            if (ov4) begin
                if (q4.size() == 0) check("S4 o_valid with empty scoreboard", 68'(ov4), 68'd0);
                else begin
                    e4 = q4.pop_front();
                    chk_out("S4", 4, e4, {32'd0, res4, c4, of4, z4, n4});
                end
            end
            if (ov1) begin
                if (q1.size() == 0) check("S1 o_valid with empty scoreboard", 68'(ov1), 68'd0);
                else begin
                    e1 = q1.pop_front();
                    chk_out("S1", 1, e1, {32'd0, res1, c1, of1, z1, n1});
                end
            end
            if (ov8) begin
                if (q8.size() == 0) check("S8 o_valid with empty scoreboard", 68'(ov8), 68'd0);
                else begin
                    e8 = q8.pop_front();
                    chk_out("S8", 8, e8, {res8, c8, of8, z8, n8});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t        dir    [6];
    vec_t        stream [8];
    vec_t        stall  [5];
    logic [35:0] snap;

    initial begin
        // Hand-computed directed vectors; flag nibble is {carry/borrow, overflow, zero, negative}.
        dir[0] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd1, op: OP_ADD, ci: 1'b0,
                   e32: rsp(64'h0, 4'b1010), e64: rsp(64'h0, 4'b1010)};
        dir[1] = '{a: 64'h7FFF_FFFF_7FFF_FFFF, b: 64'd1, op: OP_ADD, ci: 1'b0,
                   e32: rsp(64'h8000_0000, 4'b0101), e64: rsp(64'h7FFF_FFFF_8000_0000, 4'b0000)};
        dir[2] = '{a: 64'd5, b: 64'd7, op: OP_SUB, ci: 1'b0,
                   e32: rsp(64'hFFFF_FFFE, 4'b1001), e64: rsp(64'hFFFF_FFFF_FFFF_FFFE, 4'b1001)};
        dir[3] = '{a: 64'h8000_0000_8000_0000, b: 64'd1, op: OP_SUB, ci: 1'b0,
                   e32: rsp(64'h7FFF_FFFF, 4'b0100), e64: rsp(64'h8000_0000_7FFF_FFFF, 4'b0001)};
        dir[4] = '{a: 64'h0000_0001_FFFF_FFFF, b: 64'd0, op: OP_ADD, ci: 1'b1,
                   e32: rsp(64'h0, 4'b1010), e64: rsp(64'h0000_0002_0000_0000, 4'b0000)};
        dir[5] = '{a: 64'd0, b: 64'd0, op: OP_SUB, ci: 1'b1,
                   e32: rsp(64'hFFFF_FFFF, 4'b1001), e64: rsp(64'hFFFF_FFFF_FFFF_FFFF, 4'b1001)};

        stream[0] = mk(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, OP_ADD, 1'b0);
        stream[1] = mk(64'hDEAD_BEEF_CAFE_F00D, 64'h1357_9BDF_2468_ACE0, OP_SUB, 1'b0);
        stream[2] = mk(64'h8000_0000_0000_0000, 64'h8000_0000_8000_0000, OP_ADD, 1'b1);
        stream[3] = mk(64'h0000_0000_0000_0010, 64'h0000_0000_0000_0010, OP_SUB, 1'b0);
        stream[4] = mk(64'h00FF_00FF_00FF_00FF, 64'hFF00_FF00_FF00_FF01, OP_ADD, 1'b0);
        stream[5] = mk(64'h7654_3210_0000_0001, 64'h7654_3210_0000_0002, OP_SUB, 1'b1);
        stream[6] = mk(64'h5A5A_5A5A_A5A5_A5A5, 64'h3C3C_3C3C_C3C3_C3C3, OP_ADD, 1'b1);
        stream[7] = mk(64'h0000_0000_7FFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, OP_SUB, 1'b0);

        for (int i = 0; i < 5; i++)
            stall[i] = mk(64'h1111_0000_0000_0001 * 64'(i + 3), 64'(i * 977), logic'(i[0]), 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_ready low during reset", 68'({rdy4, rdy1, rdy8}), 68'd0);
        check("S4 outputs after reset", {31'd0, ov4, res4, c4, of4, z4, n4}, 68'd0);
        check("S1 outputs after reset", {31'd0, ov1, res1, c1, of1, z1, n1}, 68'd0);
        check("S8 outputs after reset", {ov8, res8[62:0], c8, of8, z8, n8}, 68'd0);
        check("S8 result msb after reset", 68'(res8[63]), 68'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready after reset release", 68'({rdy4, rdy1, rdy8}), 68'b111);
        @(posedge clk);
        #1;

        // Directed carry/overflow/borrow vectors, back to back, latency checked
        for (int i = 0; i < 6; i++) issue(dir[i], 1'b1);
        drain();

        // Eight back-to-back beats at full throughput
        for (int i = 0; i < 8; i++) issue(stream[i], 1'b1);
        drain();

        // Backpressure on the 4-stage instance: fill, hold, release with a pending beat
        solo = 1'b1;
        o_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(stall[i], 1'b0);
        @(negedge clk);
        check("S4 in_ready with full pipe", 68'(rdy4), 68'd0);
        check("S4 o_valid while stalled", 68'(ov4), 68'd1);
        snap = {res4, c4, of4, z4, n4};
        fork
            issue(stall[4], 1'b0);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("S4 output stable under stall", 68'({res4, c4, of4, z4, n4}), 68'(snap));
                    check("S4 in_ready held low", 68'({rdy4, ov4}), 68'b01);
                end
                @(posedge clk);
                #1 o_ready = 1'b1;
            end
        join
        drain();
        solo = 1'b0;

        // Reset with beats in flight: nothing may emerge afterwards
        for (int i = 0; i < 3; i++) issue(stream[i], 1'b0);
        rst = 1'b1;
        q4.delete();
        q1.delete();
        q8.delete();
        @(negedge clk);
        check("in_ready low in mid-run reset", 68'({rdy4, rdy1, rdy8}), 68'd0);
        @(posedge clk);
        @(negedge clk);
        check("valids cleared by reset", 68'({ov4, ov1, ov8}), 68'd0);
        check("S4 result cleared by reset", 68'({res4, c4, of4, z4, n4}), 68'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(negedge clk);
        check("no output after reset", 68'({ov4, ov1, ov8}), 68'd0);
        @(posedge clk);
        #1;

        // Recovery after reset
        issue(dir[3], 1'b1);
        issue(dir[0], 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
